edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and scheduler for the level-to-tick edge detection function. Each of N level inputs gets its own edge detector and a one-deep pending flag. A round-robin arbiter serialises the pending events onto a single registered valid/ready event port, tagged with the channel index. It sits between raw synchronous status levels and a single downstream event consumer, such as an interrupt or log unit.

---
 rtl/edge_event_arbiter.sv | 135 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_arbiter
//  Purpose  : Collects rising edges on N synchronous level inputs, keeps a
//             one-deep pending flag per channel, and presents the pending
//             events one at a time on a registered valid/ready port. Each
//             event is tagged with its channel index. Channels are selected
//             in round-robin order.
//  Ports    : clock    - system clock, rising-edge active
//             reset    - asynchronous active-high reset
//             level    - [N] channel levels, already synchronous to clock
//             ev_ready - consumer accepts ev_chan this cycle
//             ev_valid - event available on ev_chan
//             ev_chan  - [CHW] index of the channel whose rising edge is reported
//             pending  - [N] per-channel flags for events not yet loaded
//             ovf_clr  - (EDGE_ARB_OVF_EN only) clears all ovf bits
//             ovf      - (EDGE_ARB_OVF_EN only) [N] sticky coalescing flags
//  Options  : define EDGE_ARB_OVF_EN to add the ovf/ovf_clr overflow tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N   = 4,
    parameter int CHW = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   level,
    input  logic           ev_ready,
`ifdef EDGE_ARB_OVF_EN
    input  logic           ovf_clr,
    output logic [N-1:0]   ovf,
`endif
    output logic           ev_valid,
    output logic [CHW-1:0] ev_chan,
    output logic [N-1:0]   pending
);

    localparam logic [CHW:0] C_N = (CHW+1)'(N);

    logic [N-1:0]   r_prev;
    logic [N-1:0]   r_pending;
    logic           r_valid;
    logic [CHW-1:0] r_chan;
    logic [CHW-1:0] r_rr_ptr;

    logic [N-1:0]   w_rise;
    logic           w_free;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [CHW:0]   w_sum;
    logic [CHW:0]   w_wrap;
    logic [CHW-1:0] w_grant;
    logic [CHW:0]   w_gp1;
    logic [CHW-1:0] w_grant_nxt;
    logic           w_load;
    logic [N-1:0]   w_load_mask;

    // A level already high when reset releases is seen as a rise, since
    // r_prev comes out of reset at zero.
    assign w_rise = level & ~r_prev;
    assign w_free = ~r_valid | ev_ready;

    // Rotate pending so bit 0 is the channel at r_rr_ptr; the first set bit
    // of the rotated vector is then the round-robin winner's offset.
    assign w_rot = N'({r_pending, r_pending} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (CHW+1)'(k);
            end
        end
    end

    // r_rr_ptr < N and offset < N, so one conditional subtract wraps it.
    assign w_wrap      = (w_sum >= C_N) ? (w_sum - C_N) : w_sum;
    assign w_grant     = w_wrap[CHW-1:0];
    assign w_gp1       = {1'b0, w_grant} + (CHW+1)'(1);
    assign w_grant_nxt = (w_gp1 == C_N) ? '0 : w_gp1[CHW-1:0];

    assign w_load      = w_free & w_found;
    assign w_load_mask = w_load ? (N'(1) << w_grant) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_chan    <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_prev    <= level;
            // A fresh rise wins over the clear from loading the same channel,
            // so an edge arriving as its previous event leaves is not lost.
            r_pending <= w_rise | (r_pending & ~w_load_mask);
            if (w_free) begin
                if (w_found) begin
                    r_valid  <= 1'b1;
                    r_chan   <= w_grant;
                    r_rr_ptr <= w_grant_nxt;
                end else begin
                    r_valid  <= 1'b0;
                end
            end
        end
    end

`ifdef EDGE_ARB_OVF_EN
    logic [N-1:0] r_ovf;
    logic [N-1:0] w_coal;

    // A rise on a channel that is still pending and not being loaded now is
    // merged into the existing event; record it.
    assign w_coal = w_rise & r_pending & ~w_load_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{N{ovf_clr}}) | w_coal;
        end
    end

    assign ovf = r_ovf;
`endif

    assign ev_valid = r_valid;
    assign ev_chan  = r_chan;
    assign pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_event_arbiter
//  Purpose  : Self-checking bench for edge_event_arbiter (N=4, CHW=2).
//             Expected channel numbers are queued as edges are driven and
//             compared as the consumer accepts each event.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int CHW = 2;

    logic           clock;
    logic           reset;
    logic [N-1:0]   level;
    logic           ev_ready;
    logic           ev_valid;
    logic [CHW-1:0] ev_chan;
    logic [N-1:0]   pending;
`ifdef EDGE_ARB_OVF_EN
    logic           ovf_clr;
    logic [N-1:0]   ovf;
`endif

    int checks;
    int errors;
    int exp_q[$];

    edge_event_arbiter #(.N(N), .CHW(CHW)) dut (
        .clock    (clock),
        .reset    (reset),
        .level    (level),
        .ev_ready (ev_ready),
`ifdef EDGE_ARB_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .ev_valid (ev_valid),
        .ev_chan  (ev_chan),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clock) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed=%0d expected=none", ev_chan);
            end else begin
                chk("sb_chan", 32'(ev_chan), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        level    = '0;
        ev_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
        ovf_clr  = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst_valid",   32'(ev_valid), 32'd0);
        chk("rst_chan",    32'(ev_chan),  32'd0);
        chk("rst_pending", 32'(pending),  32'd0);
`ifdef EDGE_ARB_OVF_EN
        chk("rst_ovf",     32'(ovf),      32'd0);
`endif
        reset = 1'b0;
        cyc();

        // Simultaneous burst on all channels: served 0,1,2,3 back to back.
        ev_ready = 1'b1;
        level    = 4'hF;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        cyc();
        chk("burst_pend", 32'(pending),  32'hF);
        chk("burst_v0",   32'(ev_valid), 32'd0);
        for (int k = 0; k < N; k++) begin
            cyc();
            chk("burst_valid", 32'(ev_valid), 32'd1);
            chk("burst_chan",  32'(ev_chan),  32'(k));
        end
        cyc();
        chk("burst_end_valid", 32'(ev_valid), 32'd0);
        chk("burst_end_pend",  32'(pending),  32'd0);

        // Second burst: pointer wrapped to 0, same order again.
        level = 4'h0;
        cyc();
        level = 4'hF;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        cyc();
        for (int k = 0; k < N; k++) begin
            cyc();
            chk("burst2_chan", 32'(ev_chan), 32'(k));
        end

        // Levels held high: no further events once drained.
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("hold_valid", 32'(ev_valid), 32'd0);
            chk("hold_pend",  32'(pending),  32'd0);
        end
        level = 4'h0;
        cyc();

        // Single-cycle pulse on channel 2: event 2 cycles later for 1 cycle.
        level = 4'b0100;
        exp_q.push_back(2);
        cyc();
        chk("pulse_pend",   32'(pending),  32'b0100);
        chk("pulse_valid0", 32'(ev_valid), 32'd0);
        level = 4'b0000;
        cyc();
        chk("pulse_valid1", 32'(ev_valid), 32'd1);
        chk("pulse_chan",   32'(ev_chan),  32'd2);
        chk("pulse_pend0",  32'(pending),  32'd0);
        cyc();
        chk("pulse_valid2", 32'(ev_valid), 32'd0);

        // Stall: event 1 held while channel 3 rises.
        ev_ready = 1'b0;
        level    = 4'b0010;
        exp_q.push_back(1);
        cyc();
        level = 4'b0000;
        cyc();
        level = 4'b1000;
        exp_q.push_back(3);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_valid", 32'(ev_valid), 32'd1);
            chk("stall_chan",  32'(ev_chan),  32'd1);
            chk("stall_pend",  32'(pending),  32'b1000);
        end
        ev_ready = 1'b1;
        cyc();
        chk("stall_next_chan",  32'(ev_chan),  32'd3);
        chk("stall_next_valid", 32'(ev_valid), 32'd1);
        level = 4'b0000;
        cyc();
        chk("stall_drain", 32'(ev_valid), 32'd0);

        // Coalescing on channel 1 while its first event is stalled.
        ev_ready = 1'b0;
        level    = 4'b0010;
        exp_q.push_back(1);
        cyc();
        level = 4'b0000;
        cyc();
        chk("coal_out_chan", 32'(ev_chan), 32'd1);
        chk("coal_out_pend", 32'(pending), 32'd0);
        level = 4'b0010;
        exp_q.push_back(1);
        cyc();
        chk("coal_pend1", 32'(pending), 32'b0010);
        level = 4'b0000;
        cyc();
        level = 4'b0010;
        cyc();
        chk("coal_pend2", 32'(pending), 32'b0010);
        level = 4'b0000;
        cyc();
`ifdef EDGE_ARB_OVF_EN
        chk("ovf_set", 32'(ovf), 32'b0010);
        cyc();
        chk("ovf_sticky", 32'(ovf), 32'b0010);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
`endif
        ev_ready = 1'b1;
        cyc();
        chk("coal_second_chan", 32'(ev_chan),  32'd1);
        chk("coal_second_valid", 32'(ev_valid), 32'd1);
        cyc();
        chk("coal_done", 32'(ev_valid), 32'd0);
        cyc();
        chk("coal_no_extra", 32'(ev_valid), 32'd0);

        // Asynchronous reset while an event is valid.
        ev_ready = 1'b0;
        level    = 4'b0001;
        cyc();
        cyc();
        chk("pre_rst_valid", 32'(ev_valid), 32'd1);
        chk("pre_rst_chan",  32'(ev_chan),  32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ev_valid), 32'd0);
        chk("async_rst_pend",  32'(pending),  32'd0);
        cyc();
        // Level 0 still high across release: exactly one event.
        reset    = 1'b0;
        ev_ready = 1'b1;
        exp_q.push_back(0);
        cyc();
        chk("rel_pend", 32'(pending), 32'b0001);
        cyc();
        chk("rel_valid", 32'(ev_valid), 32'd1);
        chk("rel_chan",  32'(ev_chan),  32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rel_once", 32'(ev_valid), 32'd0);
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
